// File: rtl/mem_stage_pkg.sv
// Shared configuration for the memory stage: widths, op codes, FSM states
// and small op-decode helpers used by the stage and its sub-modules.
package mem_stage_pkg;

  localparam int ADDR_LEN     = 32;
  localparam int REG_LEN      = 32;
  localparam int REG_ADDR_LEN = 5;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Memory operation codes; any code outside 1..8 behaves like OP_NONE.
  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LBU  = 4'd4,
    OP_LHU  = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2
  } state_t;

  // True for every code that touches memory.
  function automatic logic op_is_mem(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Index of the final byte of the access (byte count minus one).
  function automatic logic [1:0] op_last_idx(input logic [3:0] op);
    logic [1:0] idx;
    case (op)
      OP_LB, OP_LBU, OP_SB: idx = 2'd0;
      OP_LH, OP_LHU, OP_SH: idx = 2'd1;
      default:              idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Sign/zero extension of an assembled load word according to the load op.
module load_extend
  import mem_stage_pkg::*;
#(
  parameter int RegLen = REG_LEN
) (
  input  logic [3:0]        op,
  input  logic [RegLen-1:0] raw,
  output logic [RegLen-1:0] ext
);

  // Pick the extension that matches the access width and signedness.
  always_comb begin
    ext = raw;
    case (op)
      OP_LB:   ext = {{(RegLen-8){raw[7]}}, raw[7:0]};
      OP_LBU:  ext = {{(RegLen-8){1'b0}}, raw[7:0]};
      OP_LH:   ext = {{(RegLen-16){raw[15]}}, raw[15:0]};
      OP_LHU:  ext = {{(RegLen-16){1'b0}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results through to write-back and runs
// loads/stores one byte at a time over a byte-wide request/grant port.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int AddrLen    = ADDR_LEN,
  parameter int RegLen     = REG_LEN,
  parameter int RegAddrLen = REG_ADDR_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [3:0]            ex_mem_op,
  input  logic                  ex_rd_enable,
  input  logic [RegAddrLen-1:0] ex_rd_addr,
  input  logic [RegLen-1:0]     ex_result,
  input  logic [RegLen-1:0]     ex_store_data,
  input  logic [AddrLen-1:0]    ex_pc,
  output logic                  stall_req,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [AddrLen-1:0]    mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_grant,
  input  logic [7:0]            mem_rdata,
  output logic                  wb_write_enable,
  output logic [RegAddrLen-1:0] wb_write_addr,
  output logic [RegLen-1:0]     wb_write_data,
  output logic [AddrLen-1:0]    wb_pc
);

  state_t                state_reg;
  logic [3:0]            op_reg;
  logic [AddrLen-1:0]    base_reg;
  logic [RegLen-1:0]     store_data_reg;
  logic                  rd_enable_reg;
  logic [RegAddrLen-1:0] rd_addr_reg;
  logic [AddrLen-1:0]    pc_reg;
  logic [1:0]            k_reg;
  logic [RegLen-1:0]     buf_reg;

  logic                  last_byte;
  logic [RegLen-1:0]     raw_word;
  logic [RegLen-1:0]     ext_word;

  assign last_byte = (k_reg == op_last_idx(op_reg));

  // Byte address wraps naturally at 2^AddrLen; outputs are pure functions of
  // the latched access, so they stay put while a grant is withheld.
  assign mem_req   = (state_reg == ST_ISSUE) && !rst;
  assign mem_wr    = (state_reg == ST_ISSUE) && op_is_store(op_reg);
  assign mem_addr  = base_reg + AddrLen'(k_reg);
  assign mem_wdata = store_data_reg[{k_reg, 3'b000} +: 8];

  // The final load byte is merged here so write-back happens on the CAPT edge.
  always_comb begin
    raw_word = buf_reg;
    raw_word[{k_reg, 3'b000} +: 8] = mem_rdata;
  end

  load_extend #(.RegLen(RegLen)) u_load_extend (
    .op  (op_reg),
    .raw (raw_word),
    .ext (ext_word)
  );

  // Hold upstream until the edge that completes the access.
  always_comb begin
    stall_req = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_IDLE:  stall_req = ex_valid && op_is_mem(ex_mem_op);
        ST_ISSUE: stall_req = !(op_is_store(op_reg) && mem_grant && last_byte);
        ST_CAPT:  stall_req = !last_byte;
        default:  stall_req = 1'b0;
      endcase
    end
  end

  // Access sequencer and registered write-back port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      op_reg          <= OP_NONE;
      base_reg        <= '0;
      store_data_reg  <= '0;
      rd_enable_reg   <= 1'b0;
      rd_addr_reg     <= '0;
      pc_reg          <= '0;
      k_reg           <= 2'd0;
      buf_reg         <= RegLen'(ZERO_WORD);
      wb_write_enable <= 1'b0;
      wb_write_addr   <= '0;
      wb_write_data   <= RegLen'(ZERO_WORD);
      wb_pc           <= '0;
    end else begin
      wb_write_enable <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (ex_valid) begin
            if (op_is_mem(ex_mem_op)) begin
              op_reg         <= ex_mem_op;
              base_reg       <= ex_result[AddrLen-1:0];
              store_data_reg <= ex_store_data;
              rd_enable_reg  <= ex_rd_enable;
              rd_addr_reg    <= ex_rd_addr;
              pc_reg         <= ex_pc;
              k_reg          <= 2'd0;
              buf_reg        <= RegLen'(ZERO_WORD);
              state_reg      <= ST_ISSUE;
            end else begin
              wb_write_enable <= ex_rd_enable;
              wb_write_addr   <= ex_rd_addr;
              wb_write_data   <= ex_result;
              wb_pc           <= ex_pc;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_grant) begin
            if (op_is_store(op_reg)) begin
              if (last_byte) begin
                state_reg <= ST_IDLE;
                wb_pc     <= pc_reg;
              end else begin
                k_reg <= k_reg + 2'd1;
              end
            end else begin
              state_reg <= ST_CAPT;
            end
          end
        end
        ST_CAPT: begin
          buf_reg[{k_reg, 3'b000} +: 8] <= mem_rdata;
          if (last_byte) begin
            state_reg       <= ST_IDLE;
            wb_write_enable <= rd_enable_reg;
            wb_write_addr   <= rd_addr_reg;
            wb_write_data   <= ext_word;
            wb_pc           <= pc_reg;
          end else begin
            k_reg     <= k_reg + 2'd1;
            state_reg <= ST_ISSUE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte memory model, access log and a
// behavioural reference for load/store results and latencies.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_mem_op;
  logic        ex_rd_enable;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic [31:0] ex_pc;
  logic        stall_req;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_grant;
  logic [7:0]  mem_rdata;
  logic        wb_write_enable;
  logic [4:0]  wb_write_addr;
  logic [31:0] wb_write_data;
  logic [31:0] wb_pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  data;
  } acc_t;
  acc_t acc_q[$];

  logic [7:0] mem_bytes [0:1023];

  always #5 clk = ~clk;

  mem_stage #(.AddrLen(32), .RegLen(32), .RegAddrLen(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_mem_op       (ex_mem_op),
    .ex_rd_enable    (ex_rd_enable),
    .ex_rd_addr      (ex_rd_addr),
    .ex_result       (ex_result),
    .ex_store_data   (ex_store_data),
    .ex_pc           (ex_pc),
    .stall_req       (stall_req),
    .mem_req         (mem_req),
    .mem_wr          (mem_wr),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_grant       (mem_grant),
    .mem_rdata       (mem_rdata),
    .wb_write_enable (wb_write_enable),
    .wb_write_addr   (wb_write_addr),
    .wb_write_data   (wb_write_data),
    .wb_pc           (wb_pc)
  );

  // Byte memory: read data appears the cycle after a granted read; every
  // granted access is logged for later comparison.
  always @(posedge clk) begin
    if (mem_req && mem_grant) begin
      if (!mem_wr) mem_rdata <= mem_bytes[mem_addr[9:0]];
      acc_q.push_back('{addr: mem_addr, wr: mem_wr, data: mem_wdata});
    end
  end

  // Reference: byte count per op (0 means no memory access).
  function automatic int nbytes(input int op);
    case (op)
      1, 4, 6: return 1;
      2, 5, 7: return 2;
      3, 8:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_store(input int op);
    return (op >= 6) && (op <= 8);
  endfunction

  // Reference: little-endian load value with sign handling for LB/LH.
  function automatic logic [31:0] model_load(input int op, input logic [31:0] base);
    longint v;
    int n;
    v = 0;
    n = nbytes(op);
    for (int i = 0; i < n; i++)
      v += longint'(mem_bytes[(base + 32'(i)) & 32'h3FF]) << (8 * i);
    if ((op == 1 || op == 2) && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  // Present one instruction and hold it until the stage accepts it.
  task automatic do_op(input logic [3:0] op, input logic rd_en, input logic [4:0] rd,
                       input logic [31:0] result, input logic [31:0] sdata,
                       input logic [31:0] pc, input bit rand_grant, input int withhold,
                       output int cycles, output int stalls, output int waits,
                       output int hold_bad);
    bit accepted, prev_wait;
    logic [31:0] p_addr;
    logic [7:0]  p_wdata;
    logic        p_wr;
    int left;
    acc_q.delete();
    ex_valid = 1'b1; ex_mem_op = op; ex_rd_enable = rd_en; ex_rd_addr = rd;
    ex_result = result; ex_store_data = sdata; ex_pc = pc;
    cycles = 0; stalls = 0; waits = 0; hold_bad = 0;
    prev_wait = 0; accepted = 0; left = withhold;
    p_addr = '0; p_wdata = '0; p_wr = 1'b0;
    while (!accepted && cycles < 200) begin
      if (mem_req && left > 0) begin
        mem_grant = 1'b0;
        left--;
      end else begin
        mem_grant = rand_grant ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      if (prev_wait && (!mem_req || mem_addr !== p_addr || mem_wdata !== p_wdata || mem_wr !== p_wr))
        hold_bad++;
      prev_wait = mem_req && !mem_grant;
      if (prev_wait) waits++;
      p_addr = mem_addr; p_wdata = mem_wdata; p_wr = mem_wr;
      if (stall_req) stalls++;
      accepted = !stall_req;
      @(posedge clk); #1;
      cycles++;
    end
    ex_valid = 1'b0;
    mem_grant = 1'b0;
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL accept_timeout: op=%0d still stalled after %0d cycles, required acceptance", op, cycles);
    end
    $display("txn op=%0d base=%h rd=%0d cycles=%0d stalls=%0d wb_en=%0b wb_data=%h",
             op, result, rd, cycles, stalls, wb_write_enable, wb_write_data);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wb_write_enable !== 1'b0) begin errors++; $display("FAIL reset_wb_en: got %b required 0", wb_write_enable); end
    checks++; if (wb_write_addr !== 5'd0) begin errors++; $display("FAIL reset_wb_addr: got %h required 0", wb_write_addr); end
    checks++; if (wb_write_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data: got %h required 0", wb_write_data); end
    checks++; if (wb_pc !== 32'd0) begin errors++; $display("FAIL reset_wb_pc: got %h required 0", wb_pc); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", stall_req); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b required 0", mem_req); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    int cyc, st, wt, hb;
    logic [3:0] op;
    logic rd_en;
    logic [4:0] rd;
    logic [31:0] res, pc;
    do_op(4'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h0, 32'h0000_0040, 0, 0, cyc, st, wt, hb);
    checks++; if (wb_write_enable !== 1'b1) begin errors++; $display("FAIL alu_wb_en: got %b required 1", wb_write_enable); end
    checks++; if (wb_write_addr !== 5'd5) begin errors++; $display("FAIL alu_wb_addr: got %0d required 5", wb_write_addr); end
    checks++; if (wb_write_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_wb_data: got %h required 12345678", wb_write_data); end
    checks++; if (cyc !== 1 || st !== 0) begin errors++; $display("FAIL alu_latency: got cycles=%0d stalls=%0d required 1/0", cyc, st); end
    @(posedge clk); #1;
    checks++; if (wb_write_enable !== 1'b0) begin errors++; $display("FAIL alu_bubble: got %b required 0", wb_write_enable); end
    for (int i = 0; i < 8; i++) begin
      op = (i % 2 == 0) ? 4'd0 : 4'($urandom_range(9, 15));
      rd_en = 1'($urandom_range(0, 1));
      rd = 5'($urandom); res = $urandom; pc = $urandom;
      do_op(op, rd_en, rd, res, $urandom, pc, 0, 0, cyc, st, wt, hb);
      checks++;
      if (wb_write_enable !== rd_en || wb_write_addr !== rd || wb_write_data !== res || wb_pc !== pc || cyc !== 1 || acc_q.size() != 0) begin
        errors++;
        $display("FAIL alu_rand: op=%0d got en=%b addr=%0d data=%h pc=%h cyc=%0d acc=%0d required en=%b addr=%0d data=%h pc=%h cyc=1 acc=0",
                 op, wb_write_enable, wb_write_addr, wb_write_data, wb_pc, cyc, acc_q.size(), rd_en, rd, res, pc);
      end
    end
  endtask

  task automatic test_lw();
    int cyc, st, wt, hb;
    mem_bytes[10'h100] = 8'h78; mem_bytes[10'h101] = 8'h56;
    mem_bytes[10'h102] = 8'h34; mem_bytes[10'h103] = 8'h12;
    do_op(4'd3, 1'b1, 5'd7, 32'h0000_0100, 32'h0, 32'h0000_0080, 0, 0, cyc, st, wt, hb);
    checks++; if (wb_write_data !== 32'h1234_5678) begin errors++; $display("FAIL lw_data: got %h required 12345678", wb_write_data); end
    checks++; if (wb_write_enable !== 1'b1 || wb_write_addr !== 5'd7 || wb_pc !== 32'h80) begin errors++; $display("FAIL lw_wb: got en=%b addr=%0d pc=%h required 1/7/80", wb_write_enable, wb_write_addr, wb_pc); end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL lw_latency: got %0d required 9", cyc); end
    checks++; if (st !== 8) begin errors++; $display("FAIL lw_stalls: got %0d required 8", st); end
    checks++; if (acc_q.size() != 4) begin errors++; $display("FAIL lw_access_count: got %0d required 4", acc_q.size()); end
    for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i].addr !== 32'h100 + 32'(i) || acc_q[i].wr !== 1'b0) begin
        errors++;
        $display("FAIL lw_addr_seq: byte %0d got addr=%h wr=%b required addr=%h wr=0", i, acc_q[i].addr, acc_q[i].wr, 32'h100 + 32'(i));
      end
    end
  endtask

  task automatic test_load_extend();
    int cyc, st, wt, hb;
    logic [3:0]  ops  [4];
    logic [31:0] addrs[4];
    logic [31:0] want [4];
    int          lat  [4];
    ops   = '{4'd1, 4'd4, 4'd2, 4'd5};
    addrs = '{32'h200, 32'h200, 32'h210, 32'h210};
    want  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8000, 32'h0000_8000};
    lat   = '{3, 3, 5, 5};
    mem_bytes[10'h200] = 8'h80;
    mem_bytes[10'h210] = 8'h00; mem_bytes[10'h211] = 8'h80;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], 1'b1, 5'(i + 1), addrs[i], 32'h0, 32'h100 + 32'(i), 0, 0, cyc, st, wt, hb);
      checks++;
      if (wb_write_data !== want[i] || wb_write_enable !== 1'b1) begin
        errors++;
        $display("FAIL load_ext: op=%0d got data=%h en=%b required data=%h en=1", ops[i], wb_write_data, wb_write_enable, want[i]);
      end
      checks++;
      if (cyc !== lat[i]) begin errors++; $display("FAIL load_latency: op=%0d got %0d required %0d", ops[i], cyc, lat[i]); end
    end
  endtask

  task automatic test_sh_wrap();
    int cyc, st, wt, hb;
    do_op(4'd0, 1'b1, 5'd9, 32'h5555_AAAA, 32'h0, 32'h0, 0, 0, cyc, st, wt, hb);
    do_op(4'd7, 1'b1, 5'd3, 32'hFFFF_FFFF, 32'hAABB_CCDD, 32'h0000_0200, 0, 3, cyc, st, wt, hb);
    checks++; if (acc_q.size() != 2) begin errors++; $display("FAIL sh_access_count: got %0d required 2", acc_q.size()); end
    if (acc_q.size() == 2) begin
      checks++;
      if (acc_q[0].addr !== 32'hFFFF_FFFF || acc_q[0].data !== 8'hDD || acc_q[0].wr !== 1'b1) begin
        errors++; $display("FAIL sh_byte0: got addr=%h data=%h wr=%b required FFFFFFFF/DD/1", acc_q[0].addr, acc_q[0].data, acc_q[0].wr);
      end
      checks++;
      if (acc_q[1].addr !== 32'h0 || acc_q[1].data !== 8'hCC || acc_q[1].wr !== 1'b1) begin
        errors++; $display("FAIL sh_byte1: got addr=%h data=%h wr=%b required 00000000/CC/1", acc_q[1].addr, acc_q[1].data, acc_q[1].wr);
      end
    end
    checks++; if (wt !== 3 || hb !== 0) begin errors++; $display("FAIL sh_hold: got waits=%0d unstable=%0d required 3/0", wt, hb); end
    checks++; if (wb_write_enable !== 1'b0 || wb_pc !== 32'h200) begin errors++; $display("FAIL sh_wb: got en=%b pc=%h required 0/200", wb_write_enable, wb_pc); end
    checks++; if (cyc !== 6) begin errors++; $display("FAIL sh_latency: got %0d required 6", cyc); end
  endtask

  task automatic test_reset_mid();
    int cyc, st, wt, hb;
    ex_valid = 1'b1; ex_mem_op = 4'd3; ex_rd_enable = 1'b1; ex_rd_addr = 5'd11;
    ex_result = 32'h100; ex_store_data = 32'h0; ex_pc = 32'h300; mem_grant = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (stall_req !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL mid_capt: got stall=%b req=%b required 1/0", stall_req, mem_req); end
    rst = 1'b1; ex_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b0 || stall_req !== 1'b0 || wb_write_enable !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got req=%b stall=%b en=%b required 0/0/0", mem_req, stall_req, wb_write_enable);
    end
    rst = 1'b0;
    ex_valid = 1'b1; mem_grant = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL issue_req: got %b required 1", mem_req); end
    rst = 1'b1; ex_valid = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_forces_req: got %b required 0", mem_req); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (wb_write_enable !== 1'b0) begin errors++; $display("FAIL abandon_no_wb: cycle %0d got %b required 0", i, wb_write_enable); end
    end
    do_op(4'd3, 1'b1, 5'd12, 32'h100, 32'h0, 32'h304, 0, 0, cyc, st, wt, hb);
    checks++; if (wb_write_data !== 32'h1234_5678 || wb_write_addr !== 5'd12 || cyc !== 9) begin
      errors++; $display("FAIL post_reset_lw: got data=%h addr=%0d cyc=%0d required 12345678/12/9", wb_write_data, wb_write_addr, cyc);
    end
  endtask

  task automatic test_random();
    int cyc, st, wt, hb, n, op;
    bit rg;
    logic rd_en;
    logic [4:0] rd;
    logic [31:0] base, sdata, pc, want;
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 15);
      n = nbytes(op);
      rg = (t % 3 != 0);
      rd_en = 1'($urandom_range(0, 1));
      rd = 5'($urandom);
      base = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FC00 | 32'($urandom_range(0, 1023))) : 32'($urandom_range(0, 1023));
      sdata = $urandom; pc = $urandom;
      want = (n == 0) ? base : model_load(op, base);
      do_op(4'(op), rd_en, rd, base, sdata, pc, rg, 0, cyc, st, wt, hb);
      checks++;
      if (is_store(op)) begin
        if (wb_write_enable !== 1'b0 || wb_pc !== pc) begin
          errors++; $display("FAIL rand_store_wb: op=%0d got en=%b pc=%h required 0/%h", op, wb_write_enable, wb_pc, pc);
        end
      end else if (wb_write_enable !== rd_en || wb_write_addr !== rd || wb_write_data !== want || wb_pc !== pc) begin
        errors++; $display("FAIL rand_wb: op=%0d base=%h got en=%b addr=%0d data=%h pc=%h required %b/%0d/%h/%h",
                           op, base, wb_write_enable, wb_write_addr, wb_write_data, wb_pc, rd_en, rd, want, pc);
      end
      checks++;
      if (acc_q.size() != n || hb != 0 || (n == 0 && cyc != 1) ||
          (n > 0 && cyc < (is_store(op) ? n + 1 : 2 * n + 1))) begin
        errors++; $display("FAIL rand_access: op=%0d got accesses=%0d cycles=%0d unstable=%0d required accesses=%0d", op, acc_q.size(), cyc, hb, n);
      end
      for (int i = 0; i < n && i < acc_q.size(); i++) begin
        checks++;
        if (acc_q[i].addr !== base + 32'(i) || acc_q[i].wr !== is_store(op) ||
            (is_store(op) && acc_q[i].data !== 8'(sdata >> (8 * i)))) begin
          errors++; $display("FAIL rand_byte: op=%0d byte %0d got addr=%h wr=%b data=%h required addr=%h wr=%b data=%h",
                             op, i, acc_q[i].addr, acc_q[i].wr, acc_q[i].data, base + 32'(i), is_store(op), 8'(sdata >> (8 * i)));
        end
      end
    end
  endtask

  initial begin
    ex_valid = 1'b0; ex_mem_op = 4'd0; ex_rd_enable = 1'b0; ex_rd_addr = 5'd0;
    ex_result = 32'h0; ex_store_data = 32'h0; ex_pc = 32'h0; mem_grant = 1'b0;
    for (int i = 0; i < 1024; i++) mem_bytes[i] = 8'($urandom);
    test_reset();
    test_alu();
    test_lw();
    test_load_extend();
    test_sh_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
